capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, is the RAMqueue depth in samples (12288 on DE0).
REQ-002 Parameter LOG2, default 9, is the address width (14 on DE0).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wrt_smpl  input  1  one-cycle strobe marking a decimated sample ready to store.
REQ-006 run  input  1  TrigCfg run bit; high requests a capture.
REQ-007 capture_done  input  1  TrigCfg capture-done bit as held by the command/config block.
REQ-008 triggered  input  1  trigger event from trigger logic, level or pulse.
REQ-009 trig_pos  input  LOG2  number of samples to store after the trigger.
REQ-010 we  output  1  RAMqueue write enable.
REQ-011 waddr  output  LOG2  RAMqueue write address; after capture it points at the oldest sample.
REQ-012 armed  output  1  enough pre-trigger samples are stored; trigger logic may fire.
REQ-013 set_capture_done  output  1  one-cycle pulse that sets the capture-done bit.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CAPTURE, DONE and WAIT_RD.
REQ-015 IDLE -> CAPTURE SHALL occur when run==1 and capture_done==0; on that edge waddr, smpl_cnt, trig_cnt and the trigger latch SHALL be cleared to 0.
REQ-016 we SHALL equal wrt_smpl while in CAPTURE (same cycle, combinational) and SHALL be 0 in every other state.
REQ-017 Each write SHALL advance waddr by 1 on the next edge; ENTRIES-1 SHALL wrap to 0.
REQ-018 smpl_cnt (LOG2+1 bits) SHALL count writes and saturate at ENTRIES.
REQ-019 The effective trig_pos SHALL be min(trig_pos, ENTRIES-1).
REQ-020 armed SHALL be registered and SHALL rise on the edge at which smpl_cnt + effective trig_pos >= ENTRIES first holds.
REQ-021 armed SHALL stay high until the FSM leaves CAPTURE, and SHALL be 0 outside CAPTURE.
REQ-022 While armed==0, triggered SHALL be ignored.
REQ-023 triggered==1 with armed==1 SHALL set the trigger latch, which SHALL stay set until the next IDLE -> CAPTURE.
REQ-024 trig_cnt SHALL increment only on writes made while the latch is already set.
REQ-025 A write coincident with the latching cycle SHALL be a pre-trigger sample and SHALL NOT increment trig_cnt.
REQ-026 CAPTURE -> DONE SHALL occur on the edge at which trig_cnt reaches the effective trig_pos.
REQ-027 If the effective trig_pos is 0, CAPTURE -> DONE SHALL occur on the edge that sets the trigger latch.
REQ-028 In DONE, set_capture_done SHALL be 1 for exactly one cycle, then the FSM SHALL go unconditionally to WAIT_RD.
REQ-029 In WAIT_RD, we SHALL be 0 and waddr SHALL be held.
REQ-030 WAIT_RD -> IDLE SHALL occur when capture_done==0 (host cleared it after the dump).
REQ-031 run==0 in CAPTURE SHALL abort to IDLE on the next edge, with no set_capture_done pulse and with waddr held.
REQ-032 run has priority over wrt_smpl and triggered in the same cycle.
REQ-033 waddr SHALL change only through REQ-015 and REQ-017 and SHALL be held in IDLE, DONE and WAIT_RD.
REQ-034 Any state and input combination not listed above SHALL leave the state and counters unchanged.

Reset
REQ-035 rst==1 at a rising edge SHALL force state=IDLE, waddr=0, smpl_cnt=0, trig_cnt=0 and trigger latch=0, from any state including mid-capture.
REQ-036 After such a reset, we, armed and set_capture_done SHALL be 0, and the block SHALL not write until a fresh run request.

Verification
REQ-037 Assert rst during CAPTURE after 50 writes -> next cycle state IDLE, waddr=0, we=0, armed=0, no set_capture_done pulse.
REQ-038 trig_pos=10, run=1, wrt_smpl every cycle -> armed rises after write 374; triggered after write 400 -> 10 more writes, then DONE, one set_capture_done pulse, final waddr=26.
REQ-039 trig_pos=10, triggered pulsed after write 100 (armed=0) -> ignored; no DONE; capture continues; a later trigger while armed completes normally.
REQ-040 run dropped after write 200 -> IDLE next cycle, waddr=200 (held), set_capture_done never asserted, we=0 thereafter.
REQ-041 Hold capture_done=1 in WAIT_RD for 20 cycles with wrt_smpl toggling -> we=0 and waddr constant; drop capture_done with run=1 -> IDLE, then CAPTURE with waddr=0.
REQ-042 trig_pos=0, trigger arrives on the cycle of write 390 -> that write counts as pre-trigger; DONE on the next edge; final waddr=6; armed was high from write 384.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// capture_ctrl_if
// Groups the signals between the trigger/config side and capture_ctrl.
//   wrt_smpl          decimated sample strobe (one cycle)
//   run               TrigCfg run bit
//   capture_done      TrigCfg capture-done bit as currently held
//   triggered         trigger event (level or pulse)
//   trig_pos          samples to keep after the trigger
//   we / waddr        RAMqueue write enable and address
//   armed             enough pre-trigger history stored
//   set_capture_done  one-cycle pulse that sets the capture-done bit
// master: the surrounding system (drives the controls).
// slave : capture_ctrl.
// -----------------------------------------------------------------------------
interface capture_ctrl_if #(
  parameter int LOG2 = 9
) ();
  logic            wrt_smpl;
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            set_capture_done;

  modport master (
    output wrt_smpl, run, capture_done, triggered, trig_pos,
    input  we, waddr, armed, set_capture_done
  );

  modport slave (
    input  wrt_smpl, run, capture_done, triggered, trig_pos,
    output we, waddr, armed, set_capture_done
  );
endinterface

// File: rtl/capture_ctrl.sv
// -----------------------------------------------------------------------------
// capture_ctrl
// Writes decimated samples into a circular RAMqueue, arms the trigger once
// enough pre-trigger history is stored, keeps trig_pos samples after the
// trigger, then signals capture-done and waits for the host to read out.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   capture_ctrl_if.slave (sample strobe, run/capture_done, trigger,
//         trig_pos in; we, waddr, armed, set_capture_done out)
// After a completed capture waddr points at the oldest stored sample.
// -----------------------------------------------------------------------------
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic          clk,
  input  logic          rst,
  capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, WAIT_RD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LOG2-1:0] r_waddr;
  logic [LOG2:0]   r_smpl_cnt;
  logic [LOG2-1:0] r_trig_cnt;
  logic            r_latch;
  logic            r_armed;

  logic            w_active;
  logic            w_wr;
  logic            w_start;
  logic [LOG2-1:0] w_eff_pos;
  logic [LOG2:0]   w_smpl_cnt_nxt;
  logic [LOG2-1:0] w_trig_cnt_nxt;
  logic            w_latch_set;
  logic            w_done;
  logic            w_arm_hit;

  // run gates everything in CAPTURE: with run low neither a write nor a
  // trigger is acted on, the block just aborts.
  assign w_active = (r_state == CAPTURE) && bus.run;
  assign w_wr     = w_active && bus.wrt_smpl;
  assign w_start  = (r_state == IDLE) && (w_state_nxt == CAPTURE);

  assign w_eff_pos = (bus.trig_pos > LOG2'(ENTRIES - 1)) ? LOG2'(ENTRIES - 1)
                                                          : bus.trig_pos;

  assign w_smpl_cnt_nxt = (w_wr && (r_smpl_cnt != (LOG2 + 1)'(ENTRIES)))
                        ? r_smpl_cnt + (LOG2 + 1)'(1) : r_smpl_cnt;

  // Only writes after the latch was already set are post-trigger samples; a
  // write in the latching cycle still belongs to the pre-trigger history.
  assign w_trig_cnt_nxt = (w_wr && r_latch) ? r_trig_cnt + LOG2'(1) : r_trig_cnt;

  // Triggers are ignored until armed, so the buffer always holds enough
  // history in front of the trigger point.
  assign w_latch_set = w_active && bus.triggered && r_armed && !r_latch;

  // A zero post-trigger length finishes on the latching edge itself.
  assign w_done = w_active &&
                  ((w_latch_set && (w_eff_pos == '0)) ||
                   (r_latch && (w_trig_cnt_nxt >= w_eff_pos)));

  assign w_arm_hit = ({1'b0, w_smpl_cnt_nxt} + {2'b00, w_eff_pos})
                     >= (LOG2 + 2)'(ENTRIES);

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps this block free of latches
  // whatever path the case takes.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.run && !bus.capture_done) w_state_nxt = CAPTURE;
      CAPTURE: if (!bus.run)                     w_state_nxt = IDLE;
               else if (w_done)                  w_state_nxt = DONE;
      DONE:                                      w_state_nxt = WAIT_RD;
      WAIT_RD: if (!bus.capture_done)            w_state_nxt = IDLE;
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.we               = w_wr;
    bus.set_capture_done = (r_state == DONE);
  end

  assign bus.waddr = r_waddr;
  assign bus.armed = r_armed;

  // Address, counters, trigger latch and armed flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr    <= '0;
      r_smpl_cnt <= '0;
      r_trig_cnt <= '0;
      r_latch    <= 1'b0;
      r_armed    <= 1'b0;
    end else if (w_start) begin
      r_waddr    <= '0;
      r_smpl_cnt <= '0;
      r_trig_cnt <= '0;
      r_latch    <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      if (w_wr)
        r_waddr <= (r_waddr == LOG2'(ENTRIES - 1)) ? '0 : r_waddr + LOG2'(1);
      r_smpl_cnt <= w_smpl_cnt_nxt;
      r_trig_cnt <= w_trig_cnt_nxt;
      if (w_latch_set) r_latch <= 1'b1;
      // Sticky while capturing, dropped on any exit from CAPTURE.
      r_armed <= (r_state == CAPTURE) && (w_state_nxt == CAPTURE) &&
                 (r_armed || w_arm_hit);
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctrl
// Directed scenarios for the documented capture sequences, followed by a
// randomized run compared cycle by cycle against a behavioural model that
// tracks total writes, post-trigger writes and the trigger/armed flags.
// -----------------------------------------------------------------------------
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int P_IDLE  = 0;
  localparam int P_CAP   = 1;
  localparam int P_DONE  = 2;
  localparam int P_WAIT  = 3;

  logic clk = 1'b0;
  logic rst;

  capture_ctrl_if #(.LOG2(LOG2)) bus ();

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  int m_phase;
  int m_writes;   // writes since the capture started
  int m_post;     // writes made after the trigger was latched
  bit m_trig;
  bit m_armed;

  logic            obs_we, obs_scd, obs_armed;
  logic [LOG2-1:0] obs_waddr;
  int              scd_count;
  logic [LOG2-1:0] tp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit run_i, input bit wrt_i,
                            input bit cd_i, input bit trg_i, input int tpv);
    int eff;
    int stored;
    bit done;
    if (r) begin
      m_phase = P_IDLE; m_writes = 0; m_post = 0; m_trig = 0; m_armed = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (run_i && !cd_i) begin
        m_phase = P_CAP; m_writes = 0; m_post = 0; m_trig = 0; m_armed = 0;
      end
      P_CAP: if (!run_i) begin
        m_phase = P_IDLE; m_armed = 0;
      end else begin
        eff = (tpv < ENTRIES - 1) ? tpv : ENTRIES - 1;
        if (wrt_i) begin
          if (m_trig) m_post++;
          m_writes++;
        end
        if (trg_i && m_armed) m_trig = 1;
        done    = m_trig && (m_post >= eff);
        stored  = (m_writes < ENTRIES) ? m_writes : ENTRIES;
        m_armed = !done && (m_armed || (stored + eff >= ENTRIES));
        if (done) m_phase = P_DONE;
      end
      P_DONE: m_phase = P_WAIT;
      P_WAIT: if (!cd_i) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  // One clock cycle: drive, sample on the falling edge, compare, advance model.
  task automatic step(input bit r, input bit run_i, input bit wrt_i,
                      input bit cd_i, input bit trg_i);
    rst              = r;
    bus.run          = run_i;
    bus.wrt_smpl     = wrt_i;
    bus.capture_done = cd_i;
    bus.triggered    = trg_i;
    bus.trig_pos     = tp;
    @(negedge clk);
    obs_we    = bus.we;
    obs_scd   = bus.set_capture_done;
    obs_armed = bus.armed;
    obs_waddr = bus.waddr;
    if (obs_scd === 1'b1) scd_count++;
    check("we",               {31'd0, obs_we},    {31'd0, (m_phase == P_CAP) && run_i && wrt_i});
    check("set_capture_done", {31'd0, obs_scd},   {31'd0, m_phase == P_DONE});
    check("armed",            {31'd0, obs_armed}, {31'd0, m_armed});
    check("waddr",            32'(obs_waddr),     32'(m_writes % ENTRIES));
    @(posedge clk);
    model_edge(r, run_i, wrt_i, cd_i, trg_i, int'(tp));
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  bit h_run;
  bit h_cd;
  bit s_r, s_w, s_t;

  initial begin
    rst = 1'b1;
    bus.run = 1'b0; bus.wrt_smpl = 1'b0; bus.capture_done = 1'b0;
    bus.triggered = 1'b0; bus.trig_pos = '0;
    tp = '0; scd_count = 0;
    m_phase = P_IDLE; m_writes = 0; m_post = 0; m_trig = 0; m_armed = 0;
    @(posedge clk); #1;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("reset_waddr", 32'(obs_waddr), 0);
    check("reset_we",    {31'd0, obs_we}, 0);
    check("reset_armed", {31'd0, obs_armed}, 0);

    // trig_pos=10, write every cycle, trigger with write 400
    tp = 9'd10; scd_count = 0;
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 400; i++) begin
      step(0, 1, 1, 0, i == 400);
      if (i == 374) check("armed_before_374", {31'd0, obs_armed}, 0);
      if (i == 375) check("armed_after_374",  {31'd0, obs_armed}, 1);
    end
    for (int i = 1; i <= 10; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    check("done_pulse", {31'd0, obs_scd}, 1);
    check("done_waddr", 32'(obs_waddr), 26);
    check("done_we",    {31'd0, obs_we}, 0);

    // Hold capture_done in WAIT_RD with wrt_smpl toggling
    for (int i = 0; i < 20; i++) begin
      step(0, 1, i[0], 1, 0);
      check("wait_we",    {31'd0, obs_we}, 0);
      check("wait_waddr", 32'(obs_waddr), 26);
    end
    check("single_pulse", 32'(scd_count), 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("restart_waddr", 32'(obs_waddr), 0);

    // Early trigger while unarmed is ignored, later trigger completes
    scd_count = 0;
    for (int i = 1; i <= 390; i++) step(0, 1, 1, 0, (i == 100) || (i == 380));
    check("early_trigger_ignored", 32'(scd_count), 0);
    step(0, 1, 0, 1, 0);
    check("late_trigger_pulse", {31'd0, obs_scd}, 1);
    check("late_trigger_waddr", 32'(obs_waddr), 6);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Abort by dropping run after write 200
    scd_count = 0;
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 200; i++) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0);
      check("abort_waddr", 32'(obs_waddr), 200);
      check("abort_we",    {31'd0, obs_we}, 0);
    end
    check("abort_no_pulse", 32'(scd_count), 0);

    // trig_pos=0, trigger coincident with write 390
    step(1, 0, 0, 0, 0);
    tp = 9'd0;
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 390; i++) begin
      step(0, 1, 1, 0, i == 390);
      if (i == 384) check("tp0_armed_before", {31'd0, obs_armed}, 0);
      if (i == 385) check("tp0_armed_after",  {31'd0, obs_armed}, 1);
    end
    step(0, 1, 1, 1, 0);
    check("tp0_pulse", {31'd0, obs_scd}, 1);
    check("tp0_waddr", 32'(obs_waddr), 6);
    step(0, 1, 0, 1, 0);

    // Reset in the middle of a capture
    step(1, 0, 0, 0, 0);
    tp = 9'd10; scd_count = 0;
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 50; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("midrst_we",    {31'd0, obs_we}, 0);
    check("midrst_armed", {31'd0, obs_armed}, 0);
    check("midrst_waddr", 32'(obs_waddr), 0);
    check("midrst_pulse", 32'(scd_count), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);

    // Randomized traffic
    h_run = 1'b1;
    h_cd  = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (m_phase == P_IDLE) begin
        case ($urandom_range(0, 4))
          0:       tp = 9'd0;
          1:       tp = 9'd10;
          2:       tp = 9'($urandom_range(0, ENTRIES - 1));
          3:       tp = 9'($urandom_range(ENTRIES, 511));
          default: tp = 9'(ENTRIES - 1);
        endcase
      end
      s_r = ($urandom_range(0, 4999) == 0);
      if (h_run) begin
        if ($urandom_range(0, 2999) == 0) h_run = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        h_run = 1'b1;
      end
      s_w = ($urandom_range(0, 3) != 0);
      s_t = ($urandom_range(0, 29) == 0);
      step(s_r, h_run, s_w, h_cd, s_t);
      if (obs_scd === 1'b1)                                            h_cd = 1'b1;
      else if (h_cd && ($urandom_range(0, 14) == 0))                   h_cd = 1'b0;
      else if (!h_cd && m_phase == P_IDLE && $urandom_range(0, 199) == 0) h_cd = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
